// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a single shared memory port and drives all datapath selects and enables.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  state_e r_state;
  state_e w_state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign state = r_state;

  // Reset masks every output combinationally, including the mem_ready-gated terms.
  always_comb begin
    w_state_next  = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    retire        = 1'b0;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (r_state)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) w_state_next = StDecode;
        end
        StDecode: begin
          alu_src_b = 2'b11;
          case (opcode)
            OpLw, OpSw: w_state_next = StMemAddr;
            OpRtype:    w_state_next = StExecute;
            OpBeq:      w_state_next = StBranch;
            OpJ:        w_state_next = StJump;
            OpAddi:     w_state_next = StAddiExec;
            default: begin
              w_state_next = StFetch;
              illegal_op   = 1'b1;
            end
          endcase
        end
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OpSw) w_state_next = StMemWrite;
          else if (opcode == OpLw) w_state_next = StMemRead;
          else w_state_next = StFetch;
        end
        StMemRead: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) w_state_next = StMemWb;
        end
        StMemWb: begin
          mem_to_reg   = 1'b1;
          reg_write    = 1'b1;
          retire       = 1'b1;
          w_state_next = StFetch;
        end
        StMemWrite: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
          if (mem_ready) w_state_next = StFetch;
        end
        StExecute: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          w_state_next = StAluWb;
        end
        StAluWb: begin
          reg_dst      = 1'b1;
          reg_write    = 1'b1;
          retire       = 1'b1;
          w_state_next = StFetch;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
          w_state_next  = StFetch;
        end
        StJump: begin
          pc_write     = 1'b1;
          pc_source    = 2'b10;
          retire       = 1'b1;
          w_state_next = StFetch;
        end
        StAddiExec: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          w_state_next = StAddiWb;
        end
        StAddiWb: begin
          reg_write    = 1'b1;
          retire       = 1'b1;
          w_state_next = StFetch;
        end
        default: w_state_next = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction expectations are
// queued at issue and checked by an independent monitor at each retire/illegal event.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, retire, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [17:0] w_outs;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .illegal_op(illegal_op), .state(state)
  );

  assign w_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire,
                   illegal_op};

  always #5 clk = ~clk;

  // Instruction kinds
  localparam int KLw = 0, KSw = 1, KR = 2, KAddi = 3, KBeq = 4, KJ = 5, KIll = 6;

  typedef struct {
    int cycles; int regw; int memw; int memr; int irw; int pcw; int pcwc; int iord;
    int ret; int ill; int pcsrc; int aluop; int regdst; int memtoreg;
  } exp_t;

  exp_t exp_q[$];
  int   st_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;
  bit   watch_regw = 1'b0;
  bit   seen_regw = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [5:0] op_of(input int kind);
    logic [5:0] op;
    case (kind)
      KLw:   op = 6'b100011;
      KSw:   op = 6'b101011;
      KR:    op = 6'b000000;
      KAddi: op = 6'b001000;
      KBeq:  op = 6'b000100;
      KJ:    op = 6'b000010;
      default: begin
        if ($urandom_range(0, 1) == 0) op = 6'b111111;
        else begin
          do op = 6'($urandom_range(0, 63));
          while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100,
                            6'b000010});
        end
      end
    endcase
    return op;
  endfunction

  // Builds the per-cycle state list, mem_ready schedule and end-of-instruction summary
  // from the instruction kind and stall counts, then drives it cycle by cycle.
  task automatic issue(input int kind, input int f, input int m);
    exp_t e;
    bit   mr[$];
    logic [5:0] op;
    bit   is_mem;
    op = op_of(kind);
    is_mem = (kind == KLw) || (kind == KSw);
    if (!is_mem) m = 0;
    for (int i = 0; i < f; i++) begin st_q.push_back(0); mr.push_back(1'b0); end
    st_q.push_back(0); mr.push_back(1'b1);
    st_q.push_back(1); mr.push_back(1'($urandom_range(0, 1)));
    case (kind)
      KLw: begin
        st_q.push_back(2); mr.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < m; i++) begin st_q.push_back(3); mr.push_back(1'b0); end
        st_q.push_back(3); mr.push_back(1'b1);
        st_q.push_back(4); mr.push_back(1'($urandom_range(0, 1)));
      end
      KSw: begin
        st_q.push_back(2); mr.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < m; i++) begin st_q.push_back(5); mr.push_back(1'b0); end
        st_q.push_back(5); mr.push_back(1'b1);
      end
      KR: begin
        st_q.push_back(6); mr.push_back(1'($urandom_range(0, 1)));
        st_q.push_back(7); mr.push_back(1'($urandom_range(0, 1)));
      end
      KAddi: begin
        st_q.push_back(10); mr.push_back(1'($urandom_range(0, 1)));
        st_q.push_back(11); mr.push_back(1'($urandom_range(0, 1)));
      end
      KBeq: begin st_q.push_back(8); mr.push_back(1'($urandom_range(0, 1))); end
      KJ:   begin st_q.push_back(9); mr.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    e.cycles   = mr.size();
    e.regw     = (kind == KLw || kind == KR || kind == KAddi) ? 1 : 0;
    e.memw     = (kind == KSw) ? m + 1 : 0;
    e.memr     = f + 1 + ((kind == KLw) ? m + 1 : 0);
    e.irw      = 1;
    e.pcw      = (kind == KJ) ? 2 : 1;
    e.pcwc     = (kind == KBeq) ? 1 : 0;
    e.iord     = is_mem ? m + 1 : 0;
    e.ret      = (kind == KIll) ? 0 : 1;
    e.ill      = (kind == KIll) ? 1 : 0;
    e.pcsrc    = (kind == KBeq) ? 1 : (kind == KJ) ? 2 : 0;
    e.aluop    = (kind == KBeq) ? 1 : 0;
    e.regdst   = (kind == KR) ? 1 : 0;
    e.memtoreg = (kind == KLw) ? 1 : 0;
    exp_q.push_back(e);
    for (int i = 0; i < e.cycles; i++) begin
      mem_ready = mr[i];
      opcode = (i <= f) ? 6'($urandom_range(0, 63)) : op;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: per-cycle state/arbitration checks, per-instruction totals at end events.
  int a_cyc = 0, a_regw = 0, a_memw = 0, a_memr = 0, a_irw = 0, a_pcw = 0, a_pcwc = 0;
  int a_iord = 0, a_ret = 0, a_ill = 0;
  int es;
  exp_t ee;

  always @(negedge clk) begin
    if (mon_en && !reset && st_q.size() > 0) begin
      es = st_q.pop_front();
      check("state", int'(state), es);
      check("rd_wr_excl", int'(mem_read & mem_write), 0);
      a_cyc++;
      a_regw += int'(reg_write); a_memw += int'(mem_write); a_memr += int'(mem_read);
      a_irw += int'(ir_write); a_pcw += int'(pc_write); a_pcwc += int'(pc_write_cond);
      a_iord += int'(i_or_d); a_ret += int'(retire); a_ill += int'(illegal_op);
      if (retire || illegal_op) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL end_event: got unexpected end, expected none (t=%0t)", $time);
        end else begin
          ee = exp_q.pop_front();
          check("cycles", a_cyc, ee.cycles);
          check("n_reg_write", a_regw, ee.regw);
          check("n_mem_write", a_memw, ee.memw);
          check("n_mem_read", a_memr, ee.memr);
          check("n_ir_write", a_irw, ee.irw);
          check("n_pc_write", a_pcw, ee.pcw);
          check("n_pc_write_cond", a_pcwc, ee.pcwc);
          check("n_i_or_d", a_iord, ee.iord);
          check("n_retire", a_ret, ee.ret);
          check("n_illegal", a_ill, ee.ill);
          check("last_pc_source", int'(pc_source), ee.pcsrc);
          check("last_alu_op", int'(alu_op), ee.aluop);
          check("last_reg_dst", int'(reg_dst), ee.regdst);
          check("last_mem_to_reg", int'(mem_to_reg), ee.memtoreg);
        end
        a_cyc = 0; a_regw = 0; a_memw = 0; a_memr = 0; a_irw = 0; a_pcw = 0;
        a_pcwc = 0; a_iord = 0; a_ret = 0; a_ill = 0;
      end
    end
  end

  always @(posedge reg_write) if (watch_regw) seen_regw = 1'b1;

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_outs", int'(w_outs), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed: lw with 2 fetch stalls and 1 read stall, then one of each kind.
    issue(KLw, 2, 1);
    issue(KAddi, 0, 0);
    issue(KSw, 0, 0);
    issue(KBeq, 0, 0);
    issue(KJ, 0, 0);
    issue(KIll, 0, 0);

    // Reset asserted while an R-type sits in EXECUTE.
    mon_en = 1'b0;
    watch_regw = 1'b1;
    seen_regw = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_state", int'(state), 6);
    #3 reset = 1'b1;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_outs", int'(w_outs), 0);
    @(posedge clk); #1;
    check("held_rst_outs", int'(w_outs), 0);
    reset = 1'b0;
    #1;
    watch_regw = 1'b0;
    check("no_reg_write_abort", int'(seen_regw), 0);
    mon_en = 1'b1;

    for (int n = 0; n < 200; n++) begin
      issue($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pending_instr", exp_q.size(), 0);
    check("pending_cycles", st_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS processor's shared-memory datapath. It sequences fetch, decode, execute, memory and write-back over several clock cycles, and drives every datapath mux select and write enable. One unified memory port serves both instruction fetch and data access; this block arbitrates it by time slot and stalls on a memory-ready handshake. It replaces the single-cycle decoder when the processor is built in multi-cycle form.

## Interface
- No parameters.
- clk  in  1  processor clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH immediately.
- opcode  in  6  instr[31:26] from instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes current access this cycle.
- pc_write, pc_write_cond  out  1 each  PC write enable; PC write qualified by ALU zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_read, mem_write, ir_write  out  1 each  memory read/write strobes; IR load.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALU out, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALU out, 10 = jump target.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- state  out  4  current state, for debug and benches.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12–15 are unreachable and return to FETCH.
- Outputs per state (every output not listed is 0):
  - FETCH: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready.
  - DECODE: alu_src_b=11.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: mem_to_reg=1, reg_write=1, retire=1.
  - MEM_WRITE: mem_write=1, i_or_d=1, retire=mem_ready.
  - EXECUTE: alu_src_a=1, alu_op=10.
  - ALU_WB: reg_dst=1, reg_write=1, retire=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, retire=1.
  - JUMP: pc_write=1, pc_source=10, retire=1.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10.
  - ADDI_WB: reg_write=1, retire=1.
- Transitions:
  - FETCH → DECODE if mem_ready, else hold.
  - DECODE dispatches by opcode: lw/sw → MEM_ADDR; R → EXECUTE; beq → BRANCH; j → JUMP; addi → ADDI_EXEC. Any other opcode → FETCH with illegal_op=1 for that DECODE cycle.
  - MEM_ADDR → MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ → MEM_WB if mem_ready, else hold.
  - MEM_WRITE → FETCH if mem_ready, else hold.
  - EXECUTE → ALU_WB; ADDI_EXEC → ADDI_WB.
  - MEM_WB, ALU_WB, BRANCH, JUMP, ADDI_WB → FETCH.
- Memory arbitration: mem_read and mem_write are never high together. i_or_d=1 only in MEM_READ and MEM_WRITE.
- During a stall, all outputs hold their state values. Write enables gated by mem_ready stay 0 until mem_ready=1.

## Timing
- Outputs are Moore outputs decoded from state; the mem_ready-gated terms are Mealy.
- While reset=1: state=0 and all outputs are 0, including mem_read and the gated terms.
- After reset falls, the first rising edge with mem_ready=1 completes FETCH.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2. Each stalled memory cycle adds 1.
- opcode is sampled only in DECODE and MEM_ADDR, because IR is stable after the FETCH cycle that loaded it.
- Reset asserted mid-instruction aborts the instruction with no further writes. A write enable already high returns to 0 combinationally with reset.

## Test plan
- addi $s1,$zero,3 with mem_ready=1: state sequence 0,1,10,11,0. reg_write=1 only in state 11 with reg_dst=0, mem_to_reg=0. retire pulses once; 4 cycles total.
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_READ: 8 cycles total. ir_write and pc_write high only in the FETCH cycle where mem_ready=1. mem_to_reg=1 in MEM_WB.
- sw with mem_ready=1: sequence 0,1,2,5,0. mem_write=1 with i_or_d=1 for exactly 1 cycle. reg_write never asserted.
- beq then j: beq takes 3 cycles with pc_write_cond=1, alu_op=01, pc_source=01. j takes 3 cycles with pc_write=1, pc_source=10.
- opcode 111111: illegal_op=1 for exactly 1 cycle in DECODE, retire stays 0, next state is FETCH.
- Reset pulsed in EXECUTE: state=0 and all outputs 0 immediately, without waiting for a clock edge. reg_write never pulses. Normal fetch resumes after reset falls.
